// File: rtl/nand_page_buffer.sv
// nand_page_buffer: byte FIFO between the NAND flash reader and the next consumer.
// Buffers the reader's byte stream in a small circular register array. It throttles
// the reader through wait_ before the FIFO can overflow, and presents bytes
// first-word-fall-through on a valid/ready handshake. Each page is framed with
// out_last and counted in page_cnt.
// Optional feature macro: NAND_PAGE_BUFFER_CHECKSUM_EN adds page_sum/sum_valid,
// a per-page 16-bit modular byte sum.
module nand_page_buffer #(
  parameter int DEPTH      = 16,
  parameter int PAGE_BYTES = 528,
  parameter int AF_MARGIN  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     wait_,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [7:0]               page_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
`ifdef NAND_PAGE_BUFFER_CHECKSUM_EN
  ,
  output logic [15:0]              page_sum,
  output logic                     sum_valid
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] MARGIN_L = LW'(AF_MARGIN);
  localparam logic [15:0]   LAST_IDX = 16'(PAGE_BYTES - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   byte_idx;
  logic          full;
  logic          push;
  logic          drop;
  logic          pop;

  // Fullness is judged on the registered level only, so a same-cycle pop never frees a slot for a push.
  assign full      = (level == DEPTH_L);
  assign push      = in_valid && !full;
  assign drop      = in_valid && full;
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // The head byte is gated by out_valid, so out_data reads 0 whenever the FIFO is empty,
  // including straight after reset. The array itself is never reset.
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  assign out_last  = out_valid && (byte_idx == LAST_IDX);
  // The free-slot margin absorbs the bytes the reader still has in flight after it sees wait_.
  assign wait_     = (DEPTH_L - level) <= MARGIN_L;

  // Storage write: the array has no reset, and a stale entry is never presented while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Page framing counts popped bytes only; dropped bytes are invisible here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= '0;
      page_cnt <= '0;
    end else if (pop) begin
      if (out_last) begin
        byte_idx <= '0;
        page_cnt <= page_cnt + 1'b1;
      end else begin
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end

`ifdef NAND_PAGE_BUFFER_CHECKSUM_EN
  logic [15:0] run_sum;
  logic [15:0] pop_sum;

  assign pop_sum = run_sum + {8'h00, out_data};

  // Running page sum. On the final byte the total is captured and the running sum restarts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_sum   <= '0;
      page_sum  <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= pop && out_last;
      if (pop) begin
        if (out_last) begin
          page_sum <= pop_sum;
          run_sum  <= '0;
        end else begin
          run_sum  <= pop_sum;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_nand_page_buffer.sv
// tb_nand_page_buffer: scoreboard bench for nand_page_buffer.
// A queue-based reference model at posedge records accepted bytes.
// A negedge monitor compares every DUT output against that model.
module tb_nand_page_buffer;

  localparam int DEPTH     = 16;
  localparam int PAGE      = 528;
  localparam int AF_MARGIN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       wait_;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic [7:0] page_cnt;
  logic       overflow;
  logic [4:0] level;
`ifdef NAND_PAGE_BUFFER_CHECKSUM_EN
  logic [15:0] page_sum;
  logic        sum_valid;
`endif

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  byte unsigned exp_q[$];
  int           model_level = 0;
  bit           exp_ovf = 1'b0;
  int           pops = 0;
  int           dut_lasts = 0;

  always #5 clk = ~clk;

  nand_page_buffer #(.DEPTH(DEPTH), .PAGE_BYTES(PAGE), .AF_MARGIN(AF_MARGIN)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .wait_(wait_),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .page_cnt(page_cnt), .overflow(overflow), .level(level)
`ifdef NAND_PAGE_BUFFER_CHECKSUM_EN
    , .page_sum(page_sum), .sum_valid(sum_valid)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && model_level != 0; i++) drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("drain_timeout", model_level, 0);
  endtask

  // Reference model: a byte is accepted when fewer than DEPTH are held, and a pop
  // needs a held byte and out_ready. Both are judged on the pre-edge count.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
      model_level = 0;
      exp_ovf = 1'b0;
    end else begin
      bit push_ok;
      bit pop_ok;
      push_ok = in_valid && (model_level < DEPTH);
      pop_ok  = out_ready && (model_level != 0);
      if (in_valid && !push_ok) exp_ovf = 1'b1;
      if (push_ok) exp_q.push_back(in_data);
      model_level = model_level + int'(push_ok) - int'(pop_ok);
    end
  end

  // Monitor: compares all outputs each negedge and consumes the expected head on a handshake.
  initial begin
    logic [15:0] run_sum;
    logic [15:0] exp_ps;
    bit          exp_sv;
    run_sum = '0;
    exp_ps  = '0;
    exp_sv  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pops = 0;
        run_sum = '0;
        exp_ps = '0;
        exp_sv = 1'b0;
      end else begin
        bit exp_last;
        bit new_sv;
        exp_last = (model_level != 0) && ((pops % PAGE) == PAGE - 1);
        chk("level", 32'(level), model_level);
        chk("out_valid", 32'(out_valid), 32'(model_level != 0));
        chk("wait_", 32'(wait_), 32'((DEPTH - model_level) <= AF_MARGIN));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("page_cnt", 32'(page_cnt), (pops / PAGE) % 256);
        chk("out_last", 32'(out_last), 32'(exp_last));
`ifdef NAND_PAGE_BUFFER_CHECKSUM_EN
        chk("sum_valid", 32'(sum_valid), 32'(exp_sv));
        chk("page_sum", 32'(page_sum), 32'(exp_ps));
`endif
        new_sv = 1'b0;
        if (model_level != 0) begin
          if (exp_q.size() == 0) begin
            chk("model_queue_empty", 32'(exp_q.size()), 32'(model_level));
          end else begin
            chk("out_data", 32'(out_data), 32'(exp_q[0]));
            if (out_ready) begin
              if (exp_last) begin
                exp_ps  = run_sum + 16'(exp_q[0]);
                run_sum = '0;
                new_sv  = 1'b1;
              end else begin
                run_sum = run_sum + 16'(exp_q[0]);
              end
              if (out_last) dut_lasts++;
              pops++;
              void'(exp_q.pop_front());
            end
          end
        end
        exp_sv = new_sv;
      end
    end
  end

  initial begin
    int lasts_before;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    chk("post_reset_level", 32'(level), 0);
    chk("post_reset_valid", 32'(out_valid), 0);
    chk("post_reset_wait", 32'(wait_), 0);

    // basic stream with consumer always ready
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b1);
    drain();
    chk("stream_overflow", 32'(overflow), 0);

    // backpressure threshold
    for (int i = 0; i < 11; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("bp_level11_wait", 32'(wait_), 0);
    drive(1'b1, 8'h4B, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("bp_level12_wait", 32'(wait_), 1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("bp_pop_level", 32'(level), 11);
    chk("bp_pop_wait", 32'(wait_), 0);
    drain();

    // overflow: 17 bytes into 16 slots
    for (int i = 0; i < 17; i++) drive(1'b1, 8'(8'hA0 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("ovf_level", 32'(level), 16);
    chk("ovf_flag", 32'(overflow), 1);
    drain();

    // asynchronous reset mid-stream at level 7
    for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h70 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("pre_reset_level", 32'(level), 7);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_level", 32'(level), 0);
    chk("async_valid", 32'(out_valid), 0);
    chk("async_data", 32'(out_data), 0);
    chk("async_last", 32'(out_last), 0);
    chk("async_page_cnt", 32'(page_cnt), 0);
    chk("async_overflow", 32'(overflow), 0);
    chk("async_wait", 32'(wait_), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    chk("rel_level", 32'(level), 0);
    chk("rel_valid", 32'(out_valid), 0);

    // two full pages
    lasts_before = dut_lasts;
    for (int i = 0; i < 2 * PAGE; i++) drive(1'b1, 8'($urandom), 1'b1);
    drain();
    chk("page_cnt_two", 32'(page_cnt), 2);
    chk("last_pulses", 32'(dut_lasts - lasts_before), 2);

    // randomized traffic; the reader mostly honours wait_
    for (int i = 0; i < 3000; i++) begin
      bit v;
      v = ($urandom % 2 == 1) && (!wait_ || ($urandom % 8 == 0));
      drive(v, 8'($urandom), ($urandom % 3) != 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
